// File: rtl/mips_exec_ctrl.sv
// Execute controller around an external combinational MIPS ALU: IDLE -> EXEC -> RESP, 2-cycle accept-to-response.
// Optional performance counters are built only when EXEC_PERF_CNT_EN is defined.
module mips_exec_ctrl #(
  parameter bit TRAP_ON_OVF    = 1'b1,
  parameter bit RF_RESET_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_reg_a,
  output logic [31:0] alu_reg_b,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags,
  output logic [4:0]  out_dest,
  output logic [1:0]  out_mem,
  output logic        branch_taken,
  output logic        exc_ovf,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

  state_t state, state_nxt;
  logic [31:0] rf [32];

  logic        accept, out_hs, dbg_wr, rf_we;
  logic [5:0]  opcode, funct;
  logic [4:0]  dest_dec, dest_exec;
  logic [1:0]  mem_dec;
  logic        ovf_op, is_lw, trap, br_dec;

  function automatic logic [31:0] rf_read(input logic [4:0] addr);
    return (addr == 5'd0) ? 32'd0 : rf[addr];
  endfunction

  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign dbg_rdata = rf_read(dbg_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode works off the latched instruction, which is what the ALU sees.
  assign opcode = alu_instr[31:26];
  assign funct  = alu_instr[5:0];

  always_comb begin
    dest_dec = 5'd0;
    mem_dec  = 2'b00;
    ovf_op   = 1'b0;
    is_lw    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB: begin
            dest_dec = alu_instr[15:11];
            ovf_op   = 1'b1;
          end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: dest_dec = alu_instr[15:11];
          default: dest_dec = 5'd0;
        endcase
      end
      OP_ADDI: begin
        dest_dec = alu_instr[20:16];
        ovf_op   = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: dest_dec = alu_instr[20:16];
      OP_LW: begin
        dest_dec = alu_instr[20:16];
        mem_dec  = 2'b01;
        is_lw    = 1'b1;
      end
      OP_SW:   mem_dec = 2'b10;
      default: dest_dec = 5'd0;
    endcase
  end

  assign trap      = ovf_op & alu_flags[0] & TRAP_ON_OVF;
  assign dest_exec = trap ? 5'd0 : dest_dec;
  assign br_dec    = ((opcode == OP_BEQ) & alu_flags[2]) | ((opcode == OP_BNE) & ~alu_flags[2]);
  // lw only reports its address; the load data never comes back through here.
  assign rf_we     = (state == EXEC) & (dest_exec != 5'd0) & ~is_lw;
  assign dbg_wr    = (state == IDLE) & dbg_we & ~in_valid & (dbg_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_instr    <= '0;
      alu_reg_a    <= '0;
      alu_reg_b    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_flags    <= '0;
      out_dest     <= '0;
      out_mem      <= '0;
      branch_taken <= 1'b0;
      exc_ovf      <= 1'b0;
    end else begin
      exc_ovf <= 1'b0;
      if (accept) begin
        alu_instr <= in_instr;
        alu_reg_a <= rf_read(in_instr[25:21]);
        alu_reg_b <= rf_read(in_instr[20:16]);
      end
      if (state == EXEC) begin
        out_valid    <= 1'b1;
        out_data     <= alu_result;
        out_flags    <= alu_flags;
        out_dest     <= dest_exec;
        out_mem      <= mem_dec;
        branch_taken <= br_dec;
        exc_ovf      <= trap;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  generate
    if (RF_RESET_CLEAR) begin : g_rf_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we) begin
          rf[dest_exec] <= alu_result;
        end else if (dbg_wr) begin
          rf[dbg_addr] <= dbg_wdata;
        end
      end
    end else begin : g_rf_keep
      // r0 is never written and always reads as zero, so no reset is needed here.
      always_ff @(posedge clk) begin
        if (rf_we)       rf[dest_exec] <= alu_result;
        else if (dbg_wr) rf[dbg_addr]  <= dbg_wdata;
      end
    end
  endgenerate

`ifdef EXEC_PERF_CNT_EN
  logic [31:0] retired_cnt, ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      ovf_cnt     <= '0;
    end else begin
      if (out_hs)  retired_cnt <= retired_cnt + 32'd1;
      if (exc_ovf) ovf_cnt     <= ovf_cnt + 32'd1;
    end
  end

  assign perf_retired = retired_cnt;
  assign perf_ovf     = ovf_cnt;
`else
  assign perf_retired = 32'd0;
  assign perf_ovf     = 32'd0;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: a bench-side ALU, an instruction-level reference model and per-cycle compare.
module tb_mips_exec_ctrl;

`ifdef EXEC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_instr, alu_reg_a, alu_reg_b, alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;
  logic [4:0]  out_dest;
  logic [1:0]  out_mem;
  logic        branch_taken, exc_ovf;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata, perf_retired, perf_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_instr(alu_instr), .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_dest(out_dest), .out_mem(out_mem),
    .branch_taken(branch_taken), .exc_ovf(exc_ovf),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .perf_retired(perf_retired), .perf_ovf(perf_ovf)
  );

  // Bench ALU: returns {zero, negative, overflow, result}; unknown ops yield a marker value.
  function automatic logic [34:0] alu_f(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, simm;
    logic v;
    simm = {{16{ins[15]}}, ins[15:0]};
    r = 32'h12345678;
    v = 1'b0;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        default: ;
      endcase
      6'h08: begin r = a + simm; v = (a[31] == simm[31]) && (r[31] != a[31]); end
      6'h09: r = a + simm;
      6'h0D: r = a | {16'h0, ins[15:0]};
      6'h04, 6'h05: r = a - b;
      6'h23, 6'h2B: r = a + simm;
      default: ;
    endcase
    return {r == 32'd0, r[31], v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_f(alu_instr, alu_reg_a, alu_reg_b);

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  flags;
    logic [4:0]  dest;
    logic [1:0]  mem;
    logic        br;
    logic        ovf;
    logic        we;
  } exp_t;

  // Expected architectural outcome of one instruction given its operand values.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [5:0] op, fn;
    logic signed_ovf_op, known;
    op = ins[31:26];
    fn = ins[5:0];
    {e.flags, e.data} = alu_f(ins, a, b);
    e.mem  = (op == 6'h23) ? 2'b01 : (op == 6'h2B) ? 2'b10 : 2'b00;
    e.br   = (op == 6'h04 && e.flags[2]) || (op == 6'h05 && !e.flags[2]);
    known  = (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B});
    signed_ovf_op = (op == 6'h08) || (op == 6'h00 && (fn == 6'h20 || fn == 6'h22));
    if (op == 6'h00)                                  e.dest = known ? ins[15:11] : 5'd0;
    else if (op inside {[6'h08:6'h0E], 6'h23})        e.dest = ins[20:16];
    else                                              e.dest = 5'd0;
    e.ovf = signed_ovf_op && e.flags[0];
    if (e.ovf) e.dest = 5'd0;
    e.we  = (e.dest != 5'd0) && (op != 6'h23);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] m_rf [32];
  logic [31:0] p_instr, p_a, p_b;
  exp_t        p;
  bit          pend;
  int          age;
  logic [31:0] m_ret, m_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend  = 1'b0;
      age   = 0;
      m_ret = '0;
      m_ovf = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_exc_ovf", {31'd0, exc_ovf}, 32'd0);
    end else begin
      chk("perf_retired", perf_retired, PERF ? m_ret : 32'd0);
      chk("perf_ovf", perf_ovf, PERF ? m_ovf : 32'd0);
      if (pend) begin
        age++;
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        if (age == 1) begin
          chk("exec_out_valid", {31'd0, out_valid}, 32'd0);
          chk("alu_instr", alu_instr, p_instr);
          chk("alu_reg_a", alu_reg_a, p_a);
          chk("alu_reg_b", alu_reg_b, p_b);
        end else begin
          if (age == 2 && p.we) m_rf[p.dest] = p.data;
          chk("out_valid", {31'd0, out_valid}, 32'd1);
          chk("out_data", out_data, p.data);
          chk("out_flags", {29'd0, out_flags}, {29'd0, p.flags});
          chk("out_dest", {27'd0, out_dest}, {27'd0, p.dest});
          chk("out_mem", {30'd0, out_mem}, {30'd0, p.mem});
          chk("branch_taken", {31'd0, branch_taken}, {31'd0, p.br});
          chk("exc_ovf", {31'd0, exc_ovf}, {31'd0, (age == 2) && p.ovf});
          if (age == 2 && p.ovf) m_ovf++;
          if (out_ready) begin
            pend = 1'b0;
            m_ret++;
          end
        end
      end else begin
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_exc_ovf", {31'd0, exc_ovf}, 32'd0);
      end
      if (in_valid && in_ready) begin
        p_instr = in_instr;
        p_a     = m_rf[in_instr[25:21]];
        p_b     = m_rf[in_instr[20:16]];
        p       = model(p_instr, p_a, p_b);
        pend    = 1'b1;
        age     = 0;
      end else if (dbg_we && in_ready && dbg_addr != 5'd0) begin
        m_rf[dbg_addr] = dbg_wdata;
      end
    end
  end

  logic [31:0] cap_data;
  logic [2:0]  cap_flags;
  logic [4:0]  cap_dest;
  logic [1:0]  cap_mem;
  logic        cap_br, cap_ovf;
  logic [31:0] rd_val;

  task automatic send(input logic [31:0] ins);
    bit ok;
    ok = 1'b0;
    in_instr = ins;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_resp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("resp_seen", {31'd0, ok}, 32'd1);
    cap_data  = out_data;
    cap_flags = out_flags;
    cap_dest  = out_dest;
    cap_mem   = out_mem;
    cap_br    = branch_taken;
    cap_ovf   = exc_ovf;
  endtask

  task automatic ack(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins);
    send(ins);
    wait_resp();
    ack(0);
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
  endtask

  task automatic dbg_read(input logic [4:0] a);
    dbg_addr = a;
    #1;
    rd_val = dbg_rdata;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    dbg_we = 1'b0; dbg_addr = 5'd5; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_alu_instr", alu_instr, 32'd0);
    chk("reset_alu_reg_a", alu_reg_a, 32'd0);
    chk("reset_dbg_rdata", dbg_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addi r1, r0, 0x35
    send(32'h20010035); wait_resp();
    chk("addi_data", cap_data, 32'h00000035);
    chk("addi_dest", {27'd0, cap_dest}, 32'd1);
    chk("addi_flags", {29'd0, cap_flags}, 32'd0);
    ack(0);
    dbg_read(5'd1); chk("addi_r1", rd_val, 32'h35);

    // signed overflow trap, then the same sum through addiu
    dbg_write(5'd1, 32'h7FFFFFFF);
    send(32'h20220035); wait_resp();
    chk("ovf_data", cap_data, 32'h80000034);
    chk("ovf_flag", {31'd0, cap_flags[0]}, 32'd1);
    chk("ovf_exc", {31'd0, cap_ovf}, 32'd1);
    chk("ovf_dest", {27'd0, cap_dest}, 32'd0);
    ack(0);
    dbg_read(5'd2); chk("ovf_r2_kept", rd_val, 32'd0);
    send(32'h24220035); wait_resp();
    chk("addiu_dest", {27'd0, cap_dest}, 32'd2);
    chk("addiu_exc", {31'd0, cap_ovf}, 32'd0);
    ack(0);
    dbg_read(5'd2); chk("addiu_r2", rd_val, 32'h80000034);

    // branches on equal operands
    dbg_write(5'd1, 32'hA);
    dbg_write(5'd2, 32'hA);
    send(32'h1022000C); wait_resp();
    chk("beq_taken", {31'd0, cap_br}, 32'd1);
    chk("beq_flags", {29'd0, cap_flags}, 32'd4);
    ack(0);
    send(32'h1422000C); wait_resp();
    chk("bne_taken", {31'd0, cap_br}, 32'd0);
    ack(0);

    // add r0, r3, r4 : result reported, r0 untouched
    dbg_write(5'd3, 32'd2);
    dbg_write(5'd4, 32'd4);
    send(32'h00640020); wait_resp();
    chk("add_r0_data", cap_data, 32'd6);
    chk("add_r0_dest", {27'd0, cap_dest}, 32'd0);
    ack(0);
    dbg_read(5'd0); chk("r0_zero", rd_val, 32'd0);

    // sub r5, r4, r3 held 5 cycles with a lw waiting behind it
    send(32'h00832822); wait_resp();
    chk("sub_data", cap_data, 32'd2);
    chk("sub_dest", {27'd0, cap_dest}, 32'd5);
    in_instr = 32'h8C230004;
    in_valid = 1'b1;
    ack(5);
    send(32'h8C230004); wait_resp();
    chk("lw_addr", cap_data, 32'h0000000E);
    chk("lw_mem", {30'd0, cap_mem}, 32'd1);
    chk("lw_dest", {27'd0, cap_dest}, 32'd3);
    ack(0);
    dbg_read(5'd3); chk("lw_no_write", rd_val, 32'd2);
    dbg_read(5'd5); chk("sub_r5", rd_val, 32'd2);

    // sw and an unsupported opcode
    send(32'hAC230004); wait_resp();
    chk("sw_mem", {30'd0, cap_mem}, 32'd2);
    chk("sw_dest", {27'd0, cap_dest}, 32'd0);
    ack(0);
    send(32'hFC220000); wait_resp();
    chk("unsup_data", cap_data, 32'h12345678);
    chk("unsup_dest", {27'd0, cap_dest}, 32'd0);
    ack(0);

    // reset while the addiu r6 is in EXEC
    send(32'h24060007);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_alu_instr", alu_instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dbg_read(5'd6); chk("midrst_r6", rd_val, 32'd0);
    dbg_read(5'd1); chk("midrst_r1_clear", rd_val, 32'd0);

    run(32'h34070001);
    run(32'h34080002);
    run(32'h34090003);
    chk("perf_three", perf_retired, PERF ? 32'd3 : 32'd0);
    dbg_read(5'd9); chk("ori_r9", rd_val, 32'd3);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
